// File: rtl/alu_regfile_pkg.sv
// Package: alu_regfile_pkg
// Shared defaults and ALU operation codes for alu_regfile_datapath.
//   DATA_W_DEF / NREGS_DEF / ADDR_W_DEF : default widths and register count
//   alu_op_e                            : SELECT encodings (100-111 reserved)
package alu_regfile_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned NREGS_DEF  = 8;
  localparam int unsigned ADDR_W_DEF = $clog2(NREGS_DEF);
  localparam int unsigned SEL_W      = 3;

  typedef enum logic [SEL_W-1:0] {
    ALU_FWD = 3'b000,
    ALU_ADD = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011
  } alu_op_e;

endpackage

// File: rtl/alu_regfile_datapath_if.sv
// Interface: alu_regfile_datapath_if
// Bus between the register-file/ALU datapath and its controller.
//   WRITE, INADDRESS, OUT1ADDRESS, OUT2ADDRESS, OPERAND2, SELECT : controller -> datapath
//   OUT1, OUT2, RESULT                                          : datapath -> controller
//   ZERO (only with ALU_ZERO_FLAG_EN defined)                   : datapath -> controller
// Modports: master (controller side), slave (datapath side).
interface alu_regfile_datapath_if
  import alu_regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned NREGS  = NREGS_DEF
);
  localparam int unsigned AW = $clog2(NREGS);

  logic              WRITE;
  logic [AW-1:0]     INADDRESS;
  logic [AW-1:0]     OUT1ADDRESS;
  logic [AW-1:0]     OUT2ADDRESS;
  logic [DATA_W-1:0] OPERAND2;
  logic [SEL_W-1:0]  SELECT;
  logic [DATA_W-1:0] OUT1;
  logic [DATA_W-1:0] OUT2;
  logic [DATA_W-1:0] RESULT;
`ifdef ALU_ZERO_FLAG_EN
  logic              ZERO;

  modport master (
    output WRITE, INADDRESS, OUT1ADDRESS, OUT2ADDRESS, OPERAND2, SELECT,
    input  OUT1, OUT2, RESULT, ZERO
  );
  modport slave (
    input  WRITE, INADDRESS, OUT1ADDRESS, OUT2ADDRESS, OPERAND2, SELECT,
    output OUT1, OUT2, RESULT, ZERO
  );
`else
  modport master (
    output WRITE, INADDRESS, OUT1ADDRESS, OUT2ADDRESS, OPERAND2, SELECT,
    input  OUT1, OUT2, RESULT
  );
  modport slave (
    input  WRITE, INADDRESS, OUT1ADDRESS, OUT2ADDRESS, OPERAND2, SELECT,
    output OUT1, OUT2, RESULT
  );
`endif

endinterface

// File: rtl/dp_alu.sv
// Module: dp_alu
// Combinational ALU.
//   DATA1  in  : first operand (register read port 1)
//   DATA2  in  : second operand (external OPERAND2)
//   SELECT in  : FWD / ADD / AND / OR; reserved codes yield 0
//   RESULT out : operation result, carry discarded
module dp_alu
  import alu_regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] DATA1,
  input  logic [DATA_W-1:0] DATA2,
  input  logic [SEL_W-1:0]  SELECT,
  output logic [DATA_W-1:0] RESULT
);

  always_comb begin
    RESULT = '0;
    case (SELECT)
      ALU_FWD: RESULT = DATA2;
      ALU_ADD: RESULT = DATA1 + DATA2;
      ALU_AND: RESULT = DATA1 & DATA2;
      ALU_OR:  RESULT = DATA1 | DATA2;
      default: RESULT = '0;
    endcase
  end

endmodule

// File: rtl/alu_regfile_datapath.sv
// Module: alu_regfile_datapath
// Register file (NREGS x DATA_W, two combinational read ports, one write
// port) feeding a dp_alu whose result is written back on WRITE.
//   CLK   in : clock, all state changes on rising edge
//   RESET in : synchronous active-high clear of every register; wins over WRITE
//   bus      : alu_regfile_datapath_if.slave (addresses, operand, select,
//              write enable in; OUT1, OUT2, RESULT out)
// Optional macro ALU_ZERO_FLAG_EN adds bus.ZERO = (RESULT == 0).
module alu_regfile_datapath
  import alu_regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned NREGS  = NREGS_DEF
) (
  input  logic                 CLK,
  input  logic                 RESET,
  alu_regfile_datapath_if.slave bus
);

  logic [DATA_W-1:0] regs [NREGS];

  // Write-back is registered, so OUT1 -> ALU -> RESULT -> regs is broken by
  // the flops; reads never bypass the write data.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.WRITE) begin
      regs[bus.INADDRESS] <= bus.RESULT;
    end
  end

  assign bus.OUT1 = regs[bus.OUT1ADDRESS];
  assign bus.OUT2 = regs[bus.OUT2ADDRESS];

  dp_alu #(.DATA_W(DATA_W)) u_alu (
    .DATA1  (bus.OUT1),
    .DATA2  (bus.OPERAND2),
    .SELECT (bus.SELECT),
    .RESULT (bus.RESULT)
  );

`ifdef ALU_ZERO_FLAG_EN
  assign bus.ZERO = (bus.RESULT == '0);
`endif

endmodule

// File: tb/tb_alu_regfile_datapath.sv
// Testbench for alu_regfile_datapath. Expected values are pushed onto a
// scoreboard queue when stimulus is applied and popped when the DUT output
// is sampled. Honours ALU_ZERO_FLAG_EN for the ZERO flag checks.
module tb_alu_regfile_datapath;
  import alu_regfile_pkg::*;

  logic CLK = 1'b0;
  logic RESET;

  alu_regfile_datapath_if bus ();

  alu_regfile_datapath dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  logic [7:0] sb [$];
  string      sb_name [$];

  // Rising edge, then step away from it before touching inputs or sampling.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Stimulus only: load a register via FWD write-back.
  task automatic load_reg(input logic [2:0] a, input logic [7:0] v);
    bus.SELECT    = ALU_FWD;
    bus.OPERAND2  = v;
    bus.INADDRESS = a;
    bus.WRITE     = 1'b1;
    tick();
    bus.WRITE     = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    string      nm;
    bus.WRITE = 1'b0;
    RESET     = 1'b1;
    tick();
    RESET     = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.OUT1ADDRESS = 3'(i);
      bus.OUT2ADDRESS = 3'(7 - i);
      sb.push_back(8'h00); sb_name.push_back($sformatf("reset_out1_r%0d", i));
      sb.push_back(8'h00); sb_name.push_back($sformatf("reset_out2_r%0d", 7 - i));
      #1;
      exp = sb.pop_front(); nm = sb_name.pop_front(); vectors++;
      if (bus.OUT1 !== exp) begin
        miscompares++;
        $display("FAIL %s got=%h want=%h", nm, bus.OUT1, exp);
      end
      exp = sb.pop_front(); nm = sb_name.pop_front(); vectors++;
      if (bus.OUT2 !== exp) begin
        miscompares++;
        $display("FAIL %s got=%h want=%h", nm, bus.OUT2, exp);
      end
    end
    // RESULT follows OPERAND2 right after reset
    bus.SELECT = ALU_FWD; bus.OPERAND2 = 8'h3C;
    sb.push_back(8'h3C); sb_name.push_back("reset_result_fwd");
    #1;
    exp = sb.pop_front(); nm = sb_name.pop_front(); vectors++;
    if (bus.RESULT !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h", nm, bus.RESULT, exp);
    end
  endtask

  task automatic test_fwd_write();
    logic [7:0] exp;
    string      nm;
    load_reg(3'd2, 8'h05);
    bus.OUT1ADDRESS = 3'd2;
    sb.push_back(8'h05); sb_name.push_back("fwd_write_r2");
    #1;
    exp = sb.pop_front(); nm = sb_name.pop_front(); vectors++;
    if (bus.OUT1 !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h", nm, bus.OUT1, exp);
    end
    bus.OPERAND2 = 8'h09; bus.INADDRESS = 3'd2; bus.WRITE = 1'b0;
    tick();
    sb.push_back(8'h05); sb_name.push_back("no_write_r2");
    #1;
    exp = sb.pop_front(); nm = sb_name.pop_front(); vectors++;
    if (bus.OUT1 !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h", nm, bus.OUT1, exp);
    end
    // register 0 is writable
    load_reg(3'd0, 8'hA5);
    bus.OUT2ADDRESS = 3'd0;
    sb.push_back(8'hA5); sb_name.push_back("r0_writable");
    #1;
    exp = sb.pop_front(); nm = sb_name.pop_front(); vectors++;
    if (bus.OUT2 !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h", nm, bus.OUT2, exp);
    end
    // reset raised between edges must not clear anything
    RESET = 1'b1;
    sb.push_back(8'hA5); sb_name.push_back("reset_no_edge");
    #3;
    exp = sb.pop_front(); nm = sb_name.pop_front(); vectors++;
    if (bus.OUT2 !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h", nm, bus.OUT2, exp);
    end
    RESET = 1'b0;
  endtask

  task automatic test_add();
    logic [7:0] exp;
    string      nm;
    load_reg(3'd1, 8'h05);
    load_reg(3'd2, 8'h03);
    load_reg(3'd5, 8'hFF);
    bus.SELECT = ALU_ADD;
    bus.OUT1ADDRESS = 3'd1; bus.OPERAND2 = 8'hFD;
    sb.push_back(8'h02); sb_name.push_back("add_sub3");
    #1;
    exp = sb.pop_front(); nm = sb_name.pop_front(); vectors++;
    if (bus.RESULT !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h", nm, bus.RESULT, exp);
    end
    bus.OUT1ADDRESS = 3'd2; bus.OPERAND2 = 8'h10;
    sb.push_back(8'h13); sb_name.push_back("add_plain");
    #1;
    exp = sb.pop_front(); nm = sb_name.pop_front(); vectors++;
    if (bus.RESULT !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h", nm, bus.RESULT, exp);
    end
    bus.OUT1ADDRESS = 3'd5; bus.OPERAND2 = 8'h01;
    sb.push_back(8'h00); sb_name.push_back("add_wrap");
    #1;
    exp = sb.pop_front(); nm = sb_name.pop_front(); vectors++;
    if (bus.RESULT !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h", nm, bus.RESULT, exp);
    end
`ifdef ALU_ZERO_FLAG_EN
    vectors++;
    if (bus.ZERO !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_set got=%b want=1", bus.ZERO);
    end
    bus.OPERAND2 = 8'h02;
    #1;
    vectors++;
    if (bus.ZERO !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_clear got=%b want=0", bus.ZERO);
    end
`endif
  endtask

  task automatic test_logic();
    logic [7:0] exp;
    string      nm;
    logic [2:0] sels [3];
    logic [7:0] want [3];
    load_reg(3'd6, 8'hCC);
    bus.OUT1ADDRESS = 3'd6; bus.OPERAND2 = 8'hAA;
    sels = '{3'b010, 3'b011, 3'b101};
    want = '{8'h88, 8'hEE, 8'h00};
    for (int i = 0; i < 3; i++) begin
      bus.SELECT = sels[i];
      sb.push_back(want[i]); sb_name.push_back($sformatf("logic_sel%b", sels[i]));
      #1;
      exp = sb.pop_front(); nm = sb_name.pop_front(); vectors++;
      if (bus.RESULT !== exp) begin
        miscompares++;
        $display("FAIL %s got=%h want=%h", nm, bus.RESULT, exp);
      end
    end
    bus.SELECT = 3'b111;
    sb.push_back(8'h00); sb_name.push_back("reserved_111");
    #1;
    exp = sb.pop_front(); nm = sb_name.pop_front(); vectors++;
    if (bus.RESULT !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h", nm, bus.RESULT, exp);
    end
  endtask

  task automatic test_reset_vs_write();
    logic [7:0] exp;
    string      nm;
    load_reg(3'd4, 8'h11);
    bus.SELECT = ALU_FWD; bus.OPERAND2 = 8'h7F; bus.INADDRESS = 3'd4;
    bus.WRITE = 1'b1; RESET = 1'b1;
    tick();
    bus.WRITE = 1'b0; RESET = 1'b0;
    bus.OUT1ADDRESS = 3'd4; bus.OUT2ADDRESS = 3'd6;
    sb.push_back(8'h00); sb_name.push_back("reset_wins_r4");
    sb.push_back(8'h00); sb_name.push_back("reset_clears_r6");
    #1;
    exp = sb.pop_front(); nm = sb_name.pop_front(); vectors++;
    if (bus.OUT1 !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h", nm, bus.OUT1, exp);
    end
    exp = sb.pop_front(); nm = sb_name.pop_front(); vectors++;
    if (bus.OUT2 !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h", nm, bus.OUT2, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    string      nm;
    logic [7:0] model;
    load_reg(3'd3, 8'h01);
    model = 8'h01;
    bus.OUT1ADDRESS = 3'd3; bus.INADDRESS = 3'd3;
    bus.SELECT = ALU_ADD; bus.OPERAND2 = 8'h01;
    // old value visible before the edge
    sb.push_back(model); sb_name.push_back("rdw_old");
    #1;
    exp = sb.pop_front(); nm = sb_name.pop_front(); vectors++;
    if (bus.OUT1 !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h", nm, bus.OUT1, exp);
    end
    bus.WRITE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      model = model + 8'h01;
      sb.push_back(model); sb_name.push_back($sformatf("b2b_edge%0d", i));
      tick();
      exp = sb.pop_front(); nm = sb_name.pop_front(); vectors++;
      if (bus.OUT1 !== exp) begin
        miscompares++;
        $display("FAIL %s got=%h want=%h", nm, bus.OUT1, exp);
      end
    end
    bus.WRITE = 1'b0;
  endtask

  initial begin
    RESET = 1'b0;
    bus.WRITE = 1'b0; bus.INADDRESS = '0; bus.OUT1ADDRESS = '0;
    bus.OUT2ADDRESS = '0; bus.OPERAND2 = '0; bus.SELECT = ALU_FWD;
    #2;
    test_reset();
    test_fwd_write();
    test_add();
    test_logic();
    test_reset_vs_write();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_regfile_datapath.md
ALU_REGFILE_DATAPATH -- requirements
Module: alu_regfile_datapath

Interface
REQ-001 Parameter DATA_W, default 8, width of every register, operand and result.
REQ-002 Parameter NREGS, default 8, register count; address width is clog2(NREGS), i.e. 3.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 CLK  input  1  clock; all state updates on rising edge.
REQ-005 RESET  input  1  synchronous active-high reset.
REQ-006 WRITE  input  1  write enable for register file write-back.
REQ-007 INADDRESS  input  3  destination register index.
REQ-008 OUT1ADDRESS  input  3  read port 1 index; the selected register feeds the ALU DATA1 input.
REQ-009 OUT2ADDRESS  input  3  read port 2 index.
REQ-010 OPERAND2  input  8  ALU DATA2 operand, supplied externally (register value, its negation, or an immediate).
REQ-011 SELECT  input  3  ALU operation code.
REQ-012 OUT1  output  8  read port 1 data.
REQ-013 OUT2  output  8  read port 2 data.
REQ-014 RESULT  output  8  ALU result, which is also the write-back data.

Function
REQ-015 Reads SHALL be combinational: OUT1 = reg[OUT1ADDRESS], OUT2 = reg[OUT2ADDRESS]; there is no write bypass.
REQ-016 ALU SHALL be combinational, with DATA1 = OUT1 and DATA2 = OPERAND2.
REQ-017 SELECT 000 (FWD): RESULT = DATA2.
REQ-018 SELECT 001 (ADD): RESULT = (DATA1 + DATA2) mod 256, carry discarded; subtraction is ADD with a two's-complement OPERAND2.
REQ-019 SELECT 010 (AND): RESULT = DATA1 & DATA2, bitwise.
REQ-020 SELECT 011 (OR): RESULT = DATA1 | DATA2, bitwise.
REQ-021 SELECT 100–111 are reserved: RESULT = 0.
REQ-022 On a rising CLK edge with RESET=0 and WRITE=1: reg[INADDRESS] <= RESULT.
REQ-023 With WRITE=0, no register changes.
REQ-024 Read-during-write to the same index SHALL return the old value before the edge and the new value after it; the loop through the edge is legal, with no combinational loop.
REQ-025 Register 0 SHALL be an ordinary writable register, not hardwired.

Reset
REQ-026 On a rising CLK edge with RESET=1, all NREGS registers SHALL be cleared to 0, and any simultaneous WRITE is ignored.
REQ-027 After reset: OUT1 = OUT2 = 0, and RESULT follows OPERAND2/SELECT combinationally.
REQ-028 Reset asserted without a clock edge SHALL not change state, because reset is synchronous.

Configuration
REQ-029 Macro ALU_ZERO_FLAG_EN: when defined, an extra output ZERO (1 bit) SHALL equal (RESULT == 0), combinational; when undefined, the ZERO port and its logic SHALL be absent and all other behaviour is identical.

Structure
REQ-030 Package alu_regfile_pkg SHALL hold DATA_W/address defaults and SELECT constants ALU_FWD=000, ALU_ADD=001, ALU_AND=010, ALU_OR=011.
REQ-031 The ALU SHALL be a sub-module dp_alu (DATA1, DATA2, SELECT -> RESULT), while the register array stays inline in the top level.

Verification
REQ-032 Scenario: RESET=1 for one edge, then read all 8 addresses -> every OUT1/OUT2 = 0x00.
REQ-033 Scenario: SELECT=000, OPERAND2=0x05, INADDRESS=2, WRITE=1, one edge -> OUT1 with OUT1ADDRESS=2 reads 0x05; a repeat with WRITE=0 and OPERAND2=0x09 leaves 0x05.
REQ-034 Scenario: r1=0x05, r2=0x03; SELECT=001, OUT1ADDRESS=1, OPERAND2=0xFD (−3) -> RESULT=0x02; with 0xFF+0x01 -> RESULT=0x00 (ZERO=1 when ALU_ZERO_FLAG_EN is defined).
REQ-035 Scenario: DATA1=0xCC, OPERAND2=0xAA -> AND gives 0x88, OR gives 0xEE; SELECT=101 -> RESULT=0x00.
REQ-036 Scenario: WRITE=1 and RESET=1 on the same edge, targeting r4 with 0x7F -> r4 reads 0x00.
REQ-037 Scenario: OUT1ADDRESS=INADDRESS=3, r3=0x01, ADD with OPERAND2=0x01 for 3 edges -> r3 reads 2, 3, 4 after successive edges.
